// File: rtl/mem_bist_pkg.sv
// rtl/mem_bist_pkg.sv - shared state type, default seed and depth helper for the memory BIST master
package mem_bist_pkg;

   typedef enum logic [2:0] {
      IDLE,
      W0,
      R0,
      C0W1,
      R1,
      C1,
      FIN
   } bist_state_e;

   localparam logic [7:0] SEED_DEFAULT = 8'hA5;

   function automatic int unsigned depth_of(input int unsigned addr_w);
      return 32'd1 << addr_w;
   endfunction

endpackage

// File: rtl/mem_bist_addr_gen.sv
// rtl/mem_bist_addr_gen.sv - up/down address counter with load and end-of-sweep flag
module mem_bist_addr_gen
   import mem_bist_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              step,
   input  logic              up,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(depth_of(ADDR_W) - 1);

   // The controller reloads at every phase boundary, so stepping never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr <= '0;
      end else if (load) begin
         addr <= load_val;
      end else if (step) begin
         addr <= up ? addr + ADDR_W'(1) : addr - ADDR_W'(1);
      end
   end

   assign last = up ? (addr == ADDR_MAX) : (addr == '0);

endmodule

// File: rtl/mem_bist_master.sv
// rtl/mem_bist_master.sv - March-style memory BIST master; MEM_BIST_ERRCNT_EN adds err_cnt and full-run mode
module mem_bist_master
   import mem_bist_pkg::*;
#(
   parameter int               ADDR_W = 8,
   parameter int               DATA_W = 8,
   parameter logic [DATA_W-1:0] SEED  = DATA_W'(SEED_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W-1:0] err_addr,
`ifdef MEM_BIST_ERRCNT_EN
   output logic [7:0]        err_cnt,
`endif
   output logic              mem_write,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   localparam int EXT_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(depth_of(ADDR_W) - 1);

   bist_state_e       state, state_nxt;
   logic              ag_load, ag_step, ag_up, ag_last;
   logic [ADDR_W-1:0] ag_load_val, addr;
   logic [EXT_W-1:0]  addr_ext;
   logic [DATA_W-1:0] pat, expect_data;
   logic              checking, miscompare, stop_on_err, start_ok;

   mem_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ag_load),
      .load_val (ag_load_val),
      .step     (ag_step),
      .up       (ag_up),
      .addr     (addr),
      .last     (ag_last)
   );

   assign addr_ext    = EXT_W'(addr);
   assign pat         = addr_ext[DATA_W-1:0] ^ SEED;
   assign checking    = (state == C0W1) || (state == C1);
   assign expect_data = (state == C0W1) ? pat : ~pat;
   assign miscompare  = checking && (mem_dout != expect_data);
   assign start_ok    = (state == IDLE) && start;
   assign ag_up       = (state == W0) || (state == R0) || (state == C0W1);

`ifdef MEM_BIST_ERRCNT_EN
   assign stop_on_err = 1'b0;
`else
   assign stop_on_err = miscompare;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      ag_load     = 1'b0;
      ag_load_val = '0;
      ag_step     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = W0;
               ag_load   = 1'b1;
            end
         end
         W0: begin
            if (ag_last) begin
               state_nxt = R0;
               ag_load   = 1'b1;
            end else begin
               ag_step = 1'b1;
            end
         end
         R0: state_nxt = C0W1;
         C0W1: begin
            if (stop_on_err) begin
               state_nxt = FIN;
            end else if (ag_last) begin
               state_nxt   = R1;
               ag_load     = 1'b1;
               ag_load_val = ADDR_MAX;
            end else begin
               state_nxt = R0;
               ag_step   = 1'b1;
            end
         end
         R1: state_nxt = C1;
         C1: begin
            if (stop_on_err || ag_last) begin
               state_nxt = FIN;
            end else begin
               state_nxt = R1;
               ag_step   = 1'b1;
            end
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes and data are decoded from state so reset silences the bus immediately.
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      mem_din   = '0;
      case (state)
         W0: begin
            busy      = 1'b1;
            mem_write = 1'b1;
            mem_din   = pat;
         end
         R0, R1: begin
            busy     = 1'b1;
            mem_read = 1'b1;
         end
         C0W1: begin
            busy      = 1'b1;
            mem_write = 1'b1;
            mem_din   = ~pat;
         end
         C1:      busy = 1'b1;
         FIN:     done = 1'b1;
         default: ;
      endcase
      mem_addr = busy ? addr : '0;
   end

   // pass doubles as the "no error seen yet" flag, so only the first miscompare latches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass     <= 1'b0;
         err_addr <= '0;
      end else if (start_ok) begin
         pass     <= 1'b1;
         err_addr <= '0;
      end else if (miscompare && pass) begin
         pass     <= 1'b0;
         err_addr <= addr;
      end
   end

`ifdef MEM_BIST_ERRCNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= 8'd0;
      end else if (start_ok) begin
         err_cnt <= 8'd0;
      end else if (miscompare && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_bist_master.sv
// tb/tb_mem_bist_master.sv - directed self-checking bench for mem_bist_master
module tb_mem_bist_master;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       busy, done, pass;
   logic [7:0] err_addr;
`ifdef MEM_BIST_ERRCNT_EN
   logic [7:0] err_cnt;
`endif
   logic       mem_write, mem_read;
   logic [7:0] mem_addr, mem_din, mem_dout;

   logic [7:0] mem [256];
   int         fault_mode;
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   mem_bist_master dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_addr  (err_addr),
`ifdef MEM_BIST_ERRCNT_EN
      .err_cnt   (err_cnt),
`endif
      .mem_write (mem_write),
      .mem_read  (mem_read),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
   );

   // fault 1: bit0 stuck-at-1 at 0x10; fault 2: bit0 inverted on read at 0x10
   function automatic logic [7:0] fault_rd(input logic [7:0] a, input logic [7:0] d);
      if (a == 8'h10 && fault_mode == 1) return d | 8'h01;
      if (a == 8'h10 && fault_mode == 2) return d ^ 8'h01;
      return d;
   endfunction

   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= mem_din;
      if (mem_read)  mem_dout <= fault_rd(mem_addr, mem[mem_addr]);
   end

   task automatic run_bist(input int restart_at, input bit fin_start, input bit check_proto,
                           output int done_at, output int nbusy, output int ndone, output int bad);
      int cyc, a, k;
      bit exp_rd, exp_wr;
      logic [7:0] exp_din;
      done_at = -1; nbusy = 0; ndone = 0; bad = 0; cyc = 0;
      @(negedge clk);
      start = 1'b1;
      while (cyc < 1500 && (done_at < 0 || cyc < done_at + 4)) begin
         @(negedge clk);
         cyc++;
         start = (cyc == restart_at);
         if (busy) nbusy++;
         if (done) begin
            ndone++;
            if (done_at < 0) done_at = cyc;
            if (fin_start) start = 1'b1;
         end
         if (mem_read && mem_write) bad++;
         if (check_proto && cyc <= 1281) begin
            a = 0; exp_rd = 0; exp_wr = 0; exp_din = 8'h00;
            if (cyc <= 256) begin
               a = cyc - 1; exp_wr = 1; exp_din = 8'(a) ^ 8'hA5;
            end else if (cyc <= 768) begin
               k = cyc - 257; a = k / 2;
               exp_rd = (k % 2 == 0); exp_wr = !exp_rd; exp_din = ~(8'(a) ^ 8'hA5);
            end else if (cyc <= 1280) begin
               k = cyc - 769; a = 255 - k / 2; exp_rd = (k % 2 == 0);
            end
            if (mem_addr !== 8'(a) || mem_read !== exp_rd || mem_write !== exp_wr) bad++;
            if (exp_wr && mem_din !== exp_din) bad++;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b1; start = 1'b0; fault_mode = 0;
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (pass !== 1'b0)      begin n_bad++; $display("FAIL reset_pass: got %b want 0", pass); end
      n_cmp++; if (err_addr !== 8'h00) begin n_bad++; $display("FAIL reset_err_addr: got %h want 00", err_addr); end
      n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
      n_cmp++; if (mem_read !== 1'b0)  begin n_bad++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
      n_cmp++; if (mem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
      n_cmp++; if (mem_din !== 8'h00)  begin n_bad++; $display("FAIL reset_mem_din: got %h want 00", mem_din); end
`ifdef MEM_BIST_ERRCNT_EN
      n_cmp++; if (err_cnt !== 8'h00)  begin n_bad++; $display("FAIL reset_err_cnt: got %h want 00", err_cnt); end
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_good_run;
      int d, nb, nd, bad;
      fault_mode = 0;
      run_bist(0, 1'b0, 1'b1, d, nb, nd, bad);
      n_cmp++; if (d !== 1281)         begin n_bad++; $display("FAIL good_done_cycle: got %0d want 1281", d); end
      n_cmp++; if (nb !== 1280)        begin n_bad++; $display("FAIL good_busy_cycles: got %0d want 1280", nb); end
      n_cmp++; if (nd !== 1)           begin n_bad++; $display("FAIL good_done_pulses: got %0d want 1", nd); end
      n_cmp++; if (bad !== 0)          begin n_bad++; $display("FAIL good_protocol: got %0d bad cycles want 0", bad); end
      n_cmp++; if (pass !== 1'b1)      begin n_bad++; $display("FAIL good_pass: got %b want 1", pass); end
      n_cmp++; if (err_addr !== 8'h00) begin n_bad++; $display("FAIL good_err_addr: got %h want 00", err_addr); end
`ifdef MEM_BIST_ERRCNT_EN
      n_cmp++; if (err_cnt !== 8'h00)  begin n_bad++; $display("FAIL good_err_cnt: got %h want 00", err_cnt); end
`endif
   endtask

   // P(0x10)=B5 already has bit0 set, so stuck-at-1 only fails the descending ~P check.
   task automatic test_stuck_at_1;
      int d, nb, nd, bad;
      fault_mode = 1;
      run_bist(0, 1'b0, 1'b0, d, nb, nd, bad);
      fault_mode = 0;
`ifdef MEM_BIST_ERRCNT_EN
      n_cmp++; if (d !== 1281)         begin n_bad++; $display("FAIL sa1_done_cycle: got %0d want 1281", d); end
      n_cmp++; if (err_cnt !== 8'd1)   begin n_bad++; $display("FAIL sa1_err_cnt: got %0d want 1", err_cnt); end
`else
      n_cmp++; if (d !== 1249)         begin n_bad++; $display("FAIL sa1_done_cycle: got %0d want 1249", d); end
`endif
      n_cmp++; if (pass !== 1'b0)      begin n_bad++; $display("FAIL sa1_pass: got %b want 0", pass); end
      n_cmp++; if (err_addr !== 8'h10) begin n_bad++; $display("FAIL sa1_err_addr: got %h want 10", err_addr); end
      n_cmp++; if (bad !== 0)          begin n_bad++; $display("FAIL sa1_strobe_overlap: got %0d want 0", bad); end
   endtask

   task automatic test_bit_flip;
      int d, nb, nd, bad;
      fault_mode = 2;
      run_bist(0, 1'b0, 1'b0, d, nb, nd, bad);
`ifdef MEM_BIST_ERRCNT_EN
      n_cmp++; if (d !== 1281)         begin n_bad++; $display("FAIL flip_done_cycle: got %0d want 1281", d); end
      n_cmp++; if (err_cnt !== 8'd2)   begin n_bad++; $display("FAIL flip_err_cnt: got %0d want 2", err_cnt); end
`else
      n_cmp++; if (d !== 291)          begin n_bad++; $display("FAIL flip_done_cycle: got %0d want 291", d); end
`endif
      n_cmp++; if (pass !== 1'b0)      begin n_bad++; $display("FAIL flip_pass: got %b want 0", pass); end
      n_cmp++; if (err_addr !== 8'h10) begin n_bad++; $display("FAIL flip_err_addr: got %h want 10", err_addr); end
   endtask

   task automatic test_back_to_back;
      int d, nb, nd, bad;
      fault_mode = 0;
      run_bist(0, 1'b0, 1'b0, d, nb, nd, bad);
      n_cmp++; if (pass !== 1'b1)      begin n_bad++; $display("FAIL b2b_pass: got %b want 1", pass); end
      n_cmp++; if (err_addr !== 8'h00) begin n_bad++; $display("FAIL b2b_err_addr: got %h want 00", err_addr); end
      n_cmp++; if (d !== 1281)         begin n_bad++; $display("FAIL b2b_done_cycle: got %0d want 1281", d); end
`ifdef MEM_BIST_ERRCNT_EN
      n_cmp++; if (err_cnt !== 8'h00)  begin n_bad++; $display("FAIL b2b_err_cnt: got %h want 00", err_cnt); end
`endif
   endtask

   task automatic test_ignored_start;
      int d, nb, nd, bad;
      fault_mode = 0;
      run_bist(50, 1'b1, 1'b0, d, nb, nd, bad);
      n_cmp++; if (d !== 1281)    begin n_bad++; $display("FAIL restart_done_cycle: got %0d want 1281", d); end
      n_cmp++; if (nb !== 1280)   begin n_bad++; $display("FAIL restart_busy_cycles: got %0d want 1280", nb); end
      n_cmp++; if (nd !== 1)      begin n_bad++; $display("FAIL restart_done_pulses: got %0d want 1", nd); end
      n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL restart_pass: got %b want 1", pass); end
   endtask

   task automatic test_reset_mid_run;
      int cnt, guard, strobes, d, nb, nd, bad;
      fault_mode = 0; cnt = 0; guard = 0; strobes = 0;
      @(negedge clk);
      start = 1'b1;
      while (cnt < 300 && guard < 1000) begin
         @(negedge clk);
         start = 1'b0;
         guard++;
         if (busy) cnt++;
      end
      n_cmp++; if (cnt !== 300) begin n_bad++; $display("FAIL rst_reach_cycle300: got %0d want 300", cnt); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if ({busy, done, pass, mem_write, mem_read} !== 5'b0)
         begin n_bad++; $display("FAIL rst_mid_flags: got %b want 00000", {busy, done, pass, mem_write, mem_read}); end
      n_cmp++; if ({err_addr, mem_addr, mem_din} !== 24'h0)
         begin n_bad++; $display("FAIL rst_mid_buses: got %h want 000000", {err_addr, mem_addr, mem_din}); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (mem_read || mem_write || busy) strobes++;
      end
      n_cmp++; if (strobes !== 0) begin n_bad++; $display("FAIL rst_no_strobes: got %0d active cycles want 0", strobes); end
      run_bist(0, 1'b0, 1'b0, d, nb, nd, bad);
      n_cmp++; if (d !== 1281 || pass !== 1'b1)
         begin n_bad++; $display("FAIL rst_rerun: got done %0d pass %b want 1281 1", d, pass); end
   endtask

   initial begin
      test_reset;
      test_good_run;
      test_stuck_at_1;
      test_bit_flip;
      test_back_to_back;
      test_ignored_start;
      test_reset_mid_run;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
